udp_axil_cmd_bridge: RTL and testbench



---
 rtl/udp_axil_cmd_bridge.sv | 354 +++++++++++++++++++++++++++++++++++
 tb/tb_udp_axil_cmd_bridge.sv | 484 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_axil_cmd_bridge.sv
// -----------------------------------------------------------------------------
// udp_axil_cmd_bridge
//
// Turns fixed-format byte command packets from the UDP RX payload stream into
// single-word AXI-Lite reads or writes. After each command it returns a 6-byte
// response packet on the outbound byte stream. One command is handled at a
// time, and everything runs in the clk domain.
//
// Command (big-endian):  op | addr[31:24] .. addr[7:0] | data[31:24] .. data[7:0]
//   op 0x01 = write (9 bytes), op 0x02 = read (5 bytes). Any extra bytes up to
//   tlast are accepted and dropped.
// Response:              op|0x80 | data[31:24] .. data[7:0] | status (tlast)
//   status 0x00 ok, 0x01 unknown opcode, 0x02 short packet, 0x03 timeout,
//   0x04 slave returned a non-OKAY response. The data field is zero for any
//   non-zero status.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   s_axis_*           command byte stream in (tdata/tvalid/tready/tlast)
//   m_axis_*           response byte stream out (tdata/tvalid/tready/tlast)
//   m_axil_aw*/w*/b*   AXI-Lite write channels (wstrb is always 4'hF)
//   m_axil_ar*/r*      AXI-Lite read channels
//   busy               high whenever the bridge is not idle
//
// Parameters:
//   ADDR_WIDTH      AXI address width. The command address is truncated to
//                   this width and word-aligned.
//   TIMEOUT_CYCLES  AXI wait limit. Used only with UDP_AXIL_BRIDGE_TIMEOUT_EN.
//
// Optional feature (compile-time macro UDP_AXIL_BRIDGE_TIMEOUT_EN):
//   When it is defined, an AXI transaction that has not completed within
//   TIMEOUT_CYCLES cycles is abandoned and reported with status 0x03. When it
//   is undefined, the bridge waits indefinitely.
// -----------------------------------------------------------------------------
module udp_axil_cmd_bridge #(
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic [7:0]            s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,

  output logic [7:0]            m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,

  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [31:0]           m_axil_wdata,
  output logic [3:0]            m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [31:0]           m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready,

  output logic                  busy
);

  localparam logic [7:0] OP_WRITE    = 8'h01;
  localparam logic [7:0] OP_READ     = 8'h02;

  localparam logic [7:0] ST_OK       = 8'h00;
  localparam logic [7:0] ST_BAD_OP   = 8'h01;
  localparam logic [7:0] ST_SHORT    = 8'h02;
  localparam logic [7:0] ST_RESP_ERR = 8'h04;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_ADDR,
    S_RX_DATA,
    S_DRAIN,
    S_AXI_WR,
    S_AXI_RD,
    S_TX_RESP
  } state_t;

  state_t                  state, state_next;

  logic [7:0]              opcode;
  logic [7:0]              status, status_next;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [31:0]             data;
  logic [1:0]              rx_cnt;       // byte index within the addr/data field
  logic [2:0]              tx_cnt;       // response byte index 0..5
  logic                    aw_valid_q, w_valid_q, ar_valid_q;
  logic                    data_clear;   // force the response data to zero
  logic                    in_hs, out_hs, r_hs;
  logic                    enter_wr, enter_rd;
  logic                    timeout_hit;

  // ---------------------------------------------------------------------------
  // Stream and AXI handshake signals
  // ---------------------------------------------------------------------------
  // tready is gated by reset so that the input reads as not-ready while reset
  // is held, even though the state is already IDLE.
  assign s_axis_tready = ~reset && (state == S_IDLE || state == S_RX_ADDR ||
                                    state == S_RX_DATA || state == S_DRAIN);
  assign in_hs         = s_axis_tvalid && s_axis_tready;

  assign m_axis_tvalid = (state == S_TX_RESP);
  assign m_axis_tlast  = (state == S_TX_RESP) && (tx_cnt == 3'd5);
  assign out_hs        = m_axis_tvalid && m_axis_tready;

  always_comb begin
    case (tx_cnt)
      3'd0:    m_axis_tdata = opcode | 8'h80;
      3'd1:    m_axis_tdata = data[31:24];
      3'd2:    m_axis_tdata = data[23:16];
      3'd3:    m_axis_tdata = data[15:8];
      3'd4:    m_axis_tdata = data[7:0];
      3'd5:    m_axis_tdata = status;
      default: m_axis_tdata = 8'h00;
    endcase
  end

  assign m_axil_awaddr  = addr & ~ADDR_WIDTH'(3);
  assign m_axil_araddr  = addr & ~ADDR_WIDTH'(3);
  assign m_axil_wdata   = data;
  assign m_axil_wstrb   = 4'hF;
  assign m_axil_awvalid = aw_valid_q;
  assign m_axil_wvalid  = w_valid_q;
  assign m_axil_arvalid = ar_valid_q;
  assign m_axil_bready  = (state == S_AXI_WR);
  // The read data channel opens only once the address has been taken.
  assign m_axil_rready  = (state == S_AXI_RD) && !ar_valid_q;
  assign r_hs           = m_axil_rvalid && m_axil_rready;

  assign busy = (state != S_IDLE);

  assign enter_wr = (state_next == S_AXI_WR) && (state != S_AXI_WR);
  assign enter_rd = (state_next == S_AXI_RD) && (state != S_AXI_RD);

  // ---------------------------------------------------------------------------
  // Optional AXI wait timeout
  // ---------------------------------------------------------------------------
`ifdef UDP_AXIL_BRIDGE_TIMEOUT_EN
  logic [31:0] wait_cnt;

  // The counter reads k in the k-th cycle (0-based) of an AXI state. The last
  // allowed cycle is therefore TIMEOUT_CYCLES-1, which keeps the request valid
  // for exactly TIMEOUT_CYCLES cycles.
  assign timeout_hit = (state == S_AXI_WR || state == S_AXI_RD) &&
                       (wait_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (enter_wr || enter_rd) begin
      wait_cnt <= '0;
    end else if (state == S_AXI_WR || state == S_AXI_RD) begin
      wait_cnt <= wait_cnt + 32'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments, so that every flop
  // samples the pre-edge values no matter how the processes are ordered.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM next state and response status
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first. Any path that
  // leaves a variable unassigned would otherwise infer a latch.
  always_comb begin
    state_next  = state;
    status_next = status;
    data_clear  = 1'b0;

    case (state)
      S_IDLE: begin
        if (in_hs) begin
          if (s_axis_tdata == OP_WRITE || s_axis_tdata == OP_READ) begin
            status_next = ST_OK;
            if (s_axis_tlast) begin
              state_next  = S_TX_RESP;
              status_next = ST_SHORT;
              data_clear  = 1'b1;
            end else begin
              state_next = S_RX_ADDR;
            end
          end else begin
            status_next = ST_BAD_OP;
            data_clear  = 1'b1;
            state_next  = s_axis_tlast ? S_TX_RESP : S_DRAIN;
          end
        end
      end

      S_RX_ADDR: begin
        if (in_hs) begin
          if (rx_cnt != 2'd3) begin
            if (s_axis_tlast) begin
              state_next  = S_TX_RESP;
              status_next = ST_SHORT;
              data_clear  = 1'b1;
            end
          end else if (opcode == OP_WRITE) begin
            if (s_axis_tlast) begin
              state_next  = S_TX_RESP;
              status_next = ST_SHORT;
              data_clear  = 1'b1;
            end else begin
              state_next = S_RX_DATA;
            end
          end else begin
            state_next = s_axis_tlast ? S_AXI_RD : S_DRAIN;
          end
        end
      end

      S_RX_DATA: begin
        if (in_hs) begin
          if (rx_cnt != 2'd3) begin
            if (s_axis_tlast) begin
              state_next  = S_TX_RESP;
              status_next = ST_SHORT;
              data_clear  = 1'b1;
            end
          end else begin
            state_next = s_axis_tlast ? S_AXI_WR : S_DRAIN;
          end
        end
      end

      // The drain destination follows from what was parsed before it: an
      // unknown opcode goes straight to the error response, and a complete
      // command goes on to its AXI transaction.
      S_DRAIN: begin
        if (in_hs && s_axis_tlast) begin
          if (status == ST_BAD_OP)     state_next = S_TX_RESP;
          else if (opcode == OP_WRITE) state_next = S_AXI_WR;
          else                         state_next = S_AXI_RD;
        end
      end

      // A completed transaction takes priority over a timeout in the same cycle.
      S_AXI_WR: begin
        if (m_axil_bvalid) begin
          state_next = S_TX_RESP;
          if (m_axil_bresp != 2'b00) begin
            status_next = ST_RESP_ERR;
            data_clear  = 1'b1;
          end
        end else if (timeout_hit) begin
          state_next  = S_TX_RESP;
          status_next = 8'h03;
          data_clear  = 1'b1;
        end
      end

      S_AXI_RD: begin
        if (r_hs) begin
          state_next = S_TX_RESP;
          if (m_axil_rresp != 2'b00) begin
            status_next = ST_RESP_ERR;
            data_clear  = 1'b1;
          end
        end else if (timeout_hit) begin
          state_next  = S_TX_RESP;
          status_next = 8'h03;
          data_clear  = 1'b1;
        end
      end

      S_TX_RESP: begin
        if (out_hs && tx_cnt == 3'd5) state_next = S_IDLE;
      end

      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: command fields, counters and AXI valids
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      opcode     <= '0;
      status     <= '0;
      addr       <= '0;
      data       <= '0;
      rx_cnt     <= '0;
      tx_cnt     <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      ar_valid_q <= 1'b0;
    end else begin
      status <= status_next;

      if (state == S_IDLE && in_hs) begin
        opcode <= s_axis_tdata;
        rx_cnt <= '0;
      end

      // The shift keeps only the low ADDR_WIDTH bits of the 32-bit address.
      if (state == S_RX_ADDR && in_hs) begin
        addr   <= ADDR_WIDTH'({addr, s_axis_tdata});
        rx_cnt <= rx_cnt + 2'd1;
      end

      if (state == S_RX_DATA && in_hs) begin
        data   <= {data[23:0], s_axis_tdata};
        rx_cnt <= rx_cnt + 2'd1;
      end

      if (r_hs) data <= m_axil_rdata;

      if (data_clear) data <= '0;

      if (state != S_TX_RESP)  tx_cnt <= '0;
      else if (out_hs)         tx_cnt <= (tx_cnt == 3'd5) ? 3'd0 : tx_cnt + 3'd1;

      // AW and W open together on entry, and each closes on its own handshake.
      if (enter_wr) begin
        aw_valid_q <= 1'b1;
        w_valid_q  <= 1'b1;
      end else if (state_next != S_AXI_WR) begin
        aw_valid_q <= 1'b0;
        w_valid_q  <= 1'b0;
      end else begin
        if (m_axil_awready) aw_valid_q <= 1'b0;
        if (m_axil_wready)  w_valid_q  <= 1'b0;
      end

      if (enter_rd)                     ar_valid_q <= 1'b1;
      else if (state_next != S_AXI_RD)  ar_valid_q <= 1'b0;
      else if (m_axil_arready)          ar_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_udp_axil_cmd_bridge.sv
// -----------------------------------------------------------------------------
// tb_udp_axil_cmd_bridge
//
// Directed bench for udp_axil_cmd_bridge. A small RAM-like AXI-Lite slave sits
// behind the bridge and can be told to return error responses or to stall AW.
// Command bytes and response bytes are driven and sampled on the falling edge.
// The expected responses in each scenario task are computed by hand.
// -----------------------------------------------------------------------------
module tb_udp_axil_cmd_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic [7:0]  s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_tready = 1'b0;
  logic        m_axis_tlast;

  logic [15:0] m_axil_awaddr, m_axil_araddr;
  logic        m_axil_awvalid, m_axil_wvalid, m_axil_bready;
  logic        m_axil_arvalid, m_axil_rready;
  logic [31:0] m_axil_wdata;
  logic [3:0]  m_axil_wstrb;
  logic        busy;

  logic        s_awready = 1'b0, s_wready = 1'b0, s_bvalid = 1'b0;
  logic        s_arready = 1'b0, s_rvalid = 1'b0;
  logic [1:0]  s_bresp = '0, s_rresp = '0;
  logic [31:0] s_rdata = '0;

  int tests = 0;
  int failures = 0;

  always #4 clk = ~clk;

  udp_axil_cmd_bridge #(.ADDR_WIDTH(16), .TIMEOUT_CYCLES(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .s_axis_tdata   (s_tdata),
    .s_axis_tvalid  (s_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tlast   (s_tlast),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_tready),
    .m_axis_tlast   (m_axis_tlast),
    .m_axil_awaddr  (m_axil_awaddr),
    .m_axil_awvalid (m_axil_awvalid),
    .m_axil_awready (s_awready),
    .m_axil_wdata   (m_axil_wdata),
    .m_axil_wstrb   (m_axil_wstrb),
    .m_axil_wvalid  (m_axil_wvalid),
    .m_axil_wready  (s_wready),
    .m_axil_bresp   (s_bresp),
    .m_axil_bvalid  (s_bvalid),
    .m_axil_bready  (m_axil_bready),
    .m_axil_araddr  (m_axil_araddr),
    .m_axil_arvalid (m_axil_arvalid),
    .m_axil_arready (s_arready),
    .m_axil_rdata   (s_rdata),
    .m_axil_rresp   (s_rresp),
    .m_axil_rvalid  (s_rvalid),
    .m_axil_rready  (m_axil_rready),
    .busy           (busy)
  );

  // ---------------------------------------------------------------------------
  // AXI-Lite slave model
  // ---------------------------------------------------------------------------
  logic [31:0] mem [0:63];
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  bit          hold_aw = 1'b0;
  bit          aw_hs, w_hs, b_hs, ar_hs, r_hs;
  bit          aw_done, w_done, ar_done;
  int          aw_count = 0, w_count = 0, ar_count = 0;
  logic [15:0] cap_awaddr = '0, cap_araddr = '0;
  logic [31:0] cap_wdata = '0;
  logic [3:0]  cap_wstrb = '0;

  initial for (int i = 0; i < 64; i++) mem[i] = 32'h0;

  // The monitor records the handshakes seen at each rising edge.
  always @(posedge clk) begin
    if (!reset) begin
      if (m_axil_awvalid && s_awready) begin
        aw_hs = 1'b1; aw_count++; cap_awaddr = m_axil_awaddr;
      end
      if (m_axil_wvalid && s_wready) begin
        w_hs = 1'b1; w_count++; cap_wdata = m_axil_wdata; cap_wstrb = m_axil_wstrb;
      end
      if (s_bvalid && m_axil_bready) b_hs = 1'b1;
      if (m_axil_arvalid && s_arready) begin
        ar_hs = 1'b1; ar_count++; cap_araddr = m_axil_araddr;
      end
      if (s_rvalid && m_axil_rready) r_hs = 1'b1;
    end
  end

  // The slave reacts to those handshakes on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      {aw_hs, w_hs, b_hs, ar_hs, r_hs} = '0;
      {aw_done, w_done, ar_done} = '0;
      {s_awready, s_wready, s_bvalid, s_arready, s_rvalid} = '0;
    end else begin
      if (aw_hs) begin aw_done = 1'b1; aw_hs = 1'b0; end
      if (w_hs)  begin w_done  = 1'b1; w_hs  = 1'b0; end
      if (ar_hs) begin ar_done = 1'b1; ar_hs = 1'b0; end
      if (b_hs)  begin b_hs = 1'b0; s_bvalid = 1'b0; aw_done = 1'b0; w_done = 1'b0; end
      if (r_hs)  begin r_hs = 1'b0; s_rvalid = 1'b0; ar_done = 1'b0; end
      s_awready = m_axil_awvalid && !aw_done && !hold_aw;
      s_wready  = m_axil_wvalid && !w_done;
      s_arready = m_axil_arvalid && !ar_done;
      if (aw_done && w_done && !s_bvalid) begin
        s_bvalid = 1'b1;
        s_bresp  = cfg_bresp;
        if (cfg_bresp == 2'b00) mem[cap_awaddr[7:2]] = cap_wdata;
      end
      if (ar_done && !s_rvalid) begin
        s_rvalid = 1'b1;
        s_rresp  = cfg_rresp;
        s_rdata  = mem[cap_araddr[7:2]];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called on a falling edge, return on a falling edge)
  // ---------------------------------------------------------------------------
  // v holds the n command bytes most-significant first.
  task automatic send_bytes(input logic [127:0] v, input int n, input bit with_last);
    int guard;
    for (int i = 0; i < n; i++) begin
      s_tdata  = v[(n-1-i)*8 +: 8];
      s_tlast  = with_last && (i == n - 1);
      s_tvalid = 1'b1;
      guard = 0;
      while (!s_axis_tready && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 200) begin
        tests++; failures++;
        $display("FAIL send_stall: byte %0d not accepted within 200 cycles", i);
      end
      @(negedge clk);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  // resp collects the response bytes with byte0 in the top byte. lasts holds
  // the tlast flag of each byte, with byte0 in bit 5. Any byte that does not
  // arrive leaves X in resp.
  task automatic recv_resp(input bit toggle, output logic [47:0] resp,
                           output logic [5:0] lasts, output int unstable);
    int          got = 0;
    int          guard = 0;
    bit          pending = 1'b0;
    logic [7:0]  held = '0;
    resp = 'x;
    lasts = 'x;
    unstable = 0;
    while (got < 6 && guard < 500) begin
      @(negedge clk);
      guard++;
      m_tready = toggle ? ~m_tready : 1'b1;
      if (pending && (!m_axis_tvalid || m_axis_tdata !== held)) unstable++;
      if (m_axis_tvalid && m_tready) begin
        resp  = {resp[39:0], m_axis_tdata};
        lasts = {lasts[4:0], m_axis_tlast};
        got++;
        pending = 1'b0;
      end else if (m_axis_tvalid) begin
        pending = 1'b1;
        held = m_axis_tdata;
      end else begin
        pending = 1'b0;
      end
    end
    @(negedge clk);
    m_tready = 1'b0;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axil_awvalid, m_axil_wvalid,
         m_axil_bready, m_axil_arvalid, m_axil_rready, busy} !== 9'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b, expected 000000000",
               {s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axil_awvalid, m_axil_wvalid,
                m_axil_bready, m_axil_arvalid, m_axil_rready, busy});
    end
    tests++;
    if ({m_axil_awaddr, m_axil_araddr, m_axil_wdata} !== 64'h0) begin
      failures++;
      $display("FAIL reset_data: got %h, expected 0", {m_axil_awaddr, m_axil_araddr, m_axil_wdata});
    end
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if ({s_axis_tready, busy} !== 2'b10) begin
      failures++;
      $display("FAIL idle_ready: got %b, expected 10", {s_axis_tready, busy});
    end
  endtask

  task automatic test_write();
    logic [47:0] r; logic [5:0] l; int u; int a0;
    a0 = aw_count;
    send_bytes(128'h01_00000010_DEADBEEF, 9, 1'b1);
    tests++;
    if ({m_axil_awvalid, m_axil_wvalid, busy} !== 3'b111) begin
      failures++;
      $display("FAIL write_valids: got %b, expected 111", {m_axil_awvalid, m_axil_wvalid, busy});
    end
    recv_resp(1'b0, r, l, u);
    tests++;
    if ({aw_count - a0, cap_awaddr, cap_wdata, cap_wstrb} !== {32'd1, 16'h0010, 32'hDEADBEEF, 4'hF}) begin
      failures++;
      $display("FAIL write_axi: got n=%0d addr=%h data=%h strb=%h, expected n=1 addr=0010 data=deadbeef strb=f",
               aw_count - a0, cap_awaddr, cap_wdata, cap_wstrb);
    end
    tests++;
    if (r !== 48'h81_DEADBEEF_00) begin
      failures++;
      $display("FAIL write_resp: got %h, expected 81deadbeef00", r);
    end
    tests++;
    if (l !== 6'b000001) begin
      failures++;
      $display("FAIL write_tlast: got %b, expected 000001", l);
    end
  endtask

  task automatic test_read();
    logic [47:0] r; logic [5:0] l; int u;
    send_bytes(128'h02_00000010, 5, 1'b1);
    recv_resp(1'b0, r, l, u);
    tests++;
    if (cap_araddr !== 16'h0010) begin
      failures++;
      $display("FAIL read_addr: got %h, expected 0010", cap_araddr);
    end
    tests++;
    if ({r, l} !== {48'h82_DEADBEEF_00, 6'b000001}) begin
      failures++;
      $display("FAIL read_resp: got %h/%b, expected 82deadbeef00/000001", r, l);
    end
    send_bytes(128'h02_00000010, 5, 1'b1);
    recv_resp(1'b1, r, l, u);
    tests++;
    if ({r, l} !== {48'h82_DEADBEEF_00, 6'b000001}) begin
      failures++;
      $display("FAIL read_toggle_resp: got %h/%b, expected 82deadbeef00/000001", r, l);
    end
    tests++;
    if (u !== 0) begin
      failures++;
      $display("FAIL read_toggle_stable: got %0d unstable stalls, expected 0", u);
    end
  endtask

  task automatic test_bad_opcode();
    logic [47:0] r; logic [5:0] l; int u; int a0, r0;
    a0 = aw_count + w_count; r0 = ar_count;
    send_bytes(128'h07_112233, 4, 1'b1);
    recv_resp(1'b0, r, l, u);
    tests++;
    if ({r, l} !== {48'h87_00000000_01, 6'b000001}) begin
      failures++;
      $display("FAIL badop_resp: got %h/%b, expected 870000000001/000001", r, l);
    end
    tests++;
    if ({aw_count + w_count - a0, ar_count - r0} !== 64'd0) begin
      failures++;
      $display("FAIL badop_noaxi: got wr=%0d rd=%0d, expected 0 0", aw_count + w_count - a0, ar_count - r0);
    end
  endtask

  task automatic test_short();
    logic [47:0] r; logic [5:0] l; int u; int a0, r0;
    a0 = aw_count + w_count; r0 = ar_count;
    send_bytes(128'h01_0000, 3, 1'b1);
    recv_resp(1'b0, r, l, u);
    tests++;
    if ({r, l} !== {48'h81_00000000_02, 6'b000001}) begin
      failures++;
      $display("FAIL short_resp: got %h/%b, expected 810000000002/000001", r, l);
    end
    send_bytes(128'h02, 1, 1'b1);
    recv_resp(1'b0, r, l, u);
    tests++;
    if (r !== 48'h82_00000000_02) begin
      failures++;
      $display("FAIL short_oponly: got %h, expected 820000000002", r);
    end
    // A write whose address is complete but whose data field is missing.
    send_bytes(128'h01_00000010_DEAD, 7, 1'b1);
    recv_resp(1'b0, r, l, u);
    tests++;
    if (r !== 48'h81_00000000_02) begin
      failures++;
      $display("FAIL short_data: got %h, expected 810000000002", r);
    end
    tests++;
    if ({aw_count + w_count - a0, ar_count - r0} !== 64'd0) begin
      failures++;
      $display("FAIL short_noaxi: got wr=%0d rd=%0d, expected 0 0", aw_count + w_count - a0, ar_count - r0);
    end
    send_bytes(128'h02_00000010, 5, 1'b1);
    recv_resp(1'b0, r, l, u);
    tests++;
    if (r !== 48'h82_DEADBEEF_00) begin
      failures++;
      $display("FAIL short_then_read: got %h, expected 82deadbeef00", r);
    end
  endtask

  task automatic test_drain_trunc();
    logic [47:0] r; logic [5:0] l; int u;
    // Address 0xABCD0027 truncates to 0x0027 and aligns down to 0x0024.
    send_bytes(128'h01_ABCD0027_12345678_AABB, 11, 1'b1);
    tests++;
    if ({m_axil_awvalid, m_axil_wvalid} !== 2'b11) begin
      failures++;
      $display("FAIL drain_valids: got %b, expected 11", {m_axil_awvalid, m_axil_wvalid});
    end
    recv_resp(1'b0, r, l, u);
    tests++;
    if ({r, cap_awaddr} !== {48'h81_12345678_00, 16'h0024}) begin
      failures++;
      $display("FAIL drain_write: got %h addr=%h, expected 811234567800 addr=0024", r, cap_awaddr);
    end
    send_bytes(128'h02_00000026_55, 6, 1'b1);
    recv_resp(1'b0, r, l, u);
    tests++;
    if ({r, cap_araddr} !== {48'h82_12345678_00, 16'h0024}) begin
      failures++;
      $display("FAIL drain_read: got %h addr=%h, expected 821234567800 addr=0024", r, cap_araddr);
    end
  endtask

  task automatic test_resp_errors();
    logic [47:0] r; logic [5:0] l; int u;
    cfg_bresp = 2'b10;
    send_bytes(128'h01_00000030_CAFEF00D, 9, 1'b1);
    recv_resp(1'b0, r, l, u);
    cfg_bresp = 2'b00;
    tests++;
    if (r !== 48'h81_00000000_04) begin
      failures++;
      $display("FAIL bresp_err: got %h, expected 810000000004", r);
    end
    cfg_rresp = 2'b10;
    send_bytes(128'h02_00000010, 5, 1'b1);
    recv_resp(1'b0, r, l, u);
    cfg_rresp = 2'b00;
    tests++;
    if (r !== 48'h82_00000000_04) begin
      failures++;
      $display("FAIL rresp_err: got %h, expected 820000000004", r);
    end
  endtask

  task automatic test_back_to_back();
    logic [47:0] r; logic [5:0] l; int u;
    send_bytes(128'h01_00000040_01020304, 9, 1'b1);
    recv_resp(1'b0, r, l, u);
    tests++;
    if ({s_axis_tready, busy} !== 2'b10) begin
      failures++;
      $display("FAIL b2b_ready: got %b, expected 10", {s_axis_tready, busy});
    end
    send_bytes(128'h02_00000040, 5, 1'b1);
    recv_resp(1'b0, r, l, u);
    tests++;
    if ({r, l} !== {48'h82_01020304_00, 6'b000001}) begin
      failures++;
      $display("FAIL b2b_read: got %h/%b, expected 820102030400/000001", r, l);
    end
  endtask

  task automatic test_reset_mid();
    logic [47:0] r; logic [5:0] l; int u;
    hold_aw = 1'b1;
    send_bytes(128'h01_00000050_0BADBEEF, 9, 1'b1);
    tests++;
    if (m_axil_awvalid !== 1'b1) begin
      failures++;
      $display("FAIL mid_awvalid: got %b, expected 1", m_axil_awvalid);
    end
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if ({m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, m_axil_bready, m_axis_tvalid, busy} !== 6'b0) begin
      failures++;
      $display("FAIL mid_reset: got %b, expected 000000",
               {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, m_axil_bready, m_axis_tvalid, busy});
    end
    @(negedge clk);
    reset = 1'b0;
    hold_aw = 1'b0;
    @(negedge clk);
    send_bytes(128'h02_00000024, 5, 1'b1);
    recv_resp(1'b0, r, l, u);
    tests++;
    if (r !== 48'h82_12345678_00) begin
      failures++;
      $display("FAIL mid_read: got %h, expected 821234567800", r);
    end
    // Abandon a partial packet. The bytes that follow form a fresh command.
    send_bytes(128'h02_00, 2, 1'b0);
    reset_dut();
    send_bytes(128'h02_00000040, 5, 1'b1);
    recv_resp(1'b0, r, l, u);
    tests++;
    if (r !== 48'h82_01020304_00) begin
      failures++;
      $display("FAIL partial_reset_read: got %h, expected 820102030400", r);
    end
  endtask

`ifdef UDP_AXIL_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    logic [47:0] r; logic [5:0] l; int u; int cnt;
    hold_aw = 1'b1;
    send_bytes(128'h01_00000060_11111111, 9, 1'b1);
    cnt = 0;
    while (m_axil_awvalid && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    tests++;
    if (cnt !== 16) begin
      failures++;
      $display("FAIL timeout_cycles: got %0d, expected 16", cnt);
    end
    recv_resp(1'b0, r, l, u);
    tests++;
    if (r !== 48'h81_00000000_03) begin
      failures++;
      $display("FAIL timeout_resp: got %h, expected 810000000003", r);
    end
    hold_aw = 1'b0;
    reset_dut();
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_bad_opcode();
    test_short();
    test_drain_trunc();
    test_resp_errors();
    test_back_to_back();
    test_reset_mid();
`ifdef UDP_AXIL_BRIDGE_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
